vc_arbiter: RTL and testbench

- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Pops words from VC0/VC1 by weighted round-robin, stalls on downstream back-pressure, and routes each popped word to D0 or D1 by a destination bit.
- Sits after the VC FIFO pair and drives their pop inputs; its push outputs feed the destination FIFOs.

---
 rtl/vc_arbiter_if.sv | 34 +++
 rtl/vc_arbiter.sv | 102 ++++++++++
 tb/tb_vc_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vc_arbiter_if.sv
// Bundle of the VC FIFO pop side and destination FIFO push side seen by vc_arbiter.
// The arbiter uses the master modport; the FIFO environment uses the slave modport.
interface vc_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc0_almost_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic                  vc1_empty;
  logic                  vc1_almost_empty;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] d0_data;
  logic [DATA_WIDTH-1:0] d1_data;

  modport master (
    input  vc0_empty, vc0_almost_empty, vc0_data,
    input  vc1_empty, vc1_almost_empty, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data
  );

  modport slave (
    output vc0_empty, vc0_almost_empty, vc0_data,
    output vc1_empty, vc1_almost_empty, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data
  );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler popping two VC FIFOs and routing each popped word
// to destination FIFO D0 or D1 by one bit of the word, two cycles after its pop.
module vc_arbiter #(
  parameter int data_width = 6,
  parameter int WEIGHT0    = 3,
  parameter int WEIGHT1    = 1,
  parameter int DEST_BIT   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable_i,
  output logic         idle_o,
  vc_arbiter_if.master bus
);
  localparam logic [2:0] W0 = 3'(WEIGHT0);
  localparam logic [2:0] W1 = 3'(WEIGHT1);

  logic                  vc0_pop_q, vc1_pop_q, vc0_pop_d, vc1_pop_d;
  logic                  cur_q, cur_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  valid1_q, src1_q;
  logic                  d0_push_q, d1_push_q, d0_push_d, d1_push_d;
  logic [data_width-1:0] d0_data_q, d1_data_q, d0_data_d, d1_data_d;

  logic                  paused, elig0, elig1, cur_elig, oth_elig;
  logic [2:0]            weight;
  logic                  grant_v, grant_sel;
  logic [data_width-1:0] word;
  logic                  to_d1;

  // A FIFO whose last word is being popped this cycle must not be popped again.
  always_comb begin
    paused   = bus.d0_almost_full | bus.d1_almost_full;
    elig0    = enable_i & ~paused & ~(bus.vc0_empty | (vc0_pop_q & bus.vc0_almost_empty));
    elig1    = enable_i & ~paused & ~(bus.vc1_empty | (vc1_pop_q & bus.vc1_almost_empty));
    cur_elig = cur_q ? elig1 : elig0;
    oth_elig = cur_q ? elig0 : elig1;
    weight   = cur_q ? W1 : W0;

    cur_d     = cur_q;
    cnt_d     = cnt_q;
    grant_v   = 1'b0;
    grant_sel = cur_q;
    if (cur_elig && ((cnt_q < weight) || !oth_elig)) begin
      grant_v = 1'b1;
      cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
    end else if (oth_elig) begin
      grant_v   = 1'b1;
      grant_sel = ~cur_q;
      cur_d     = ~cur_q;
      cnt_d     = 3'd1;
    end
    vc0_pop_d = grant_v & ~grant_sel;
    vc1_pop_d = grant_v & grant_sel;
  end

  // Stage 2: the FIFO read data for the word popped two cycles ago is valid now.
  always_comb begin
    word      = src1_q ? bus.vc1_data : bus.vc0_data;
    to_d1     = word[DEST_BIT];
    d0_push_d = valid1_q & ~to_d1;
    d1_push_d = valid1_q & to_d1;
    d0_data_d = d0_push_d ? word : d0_data_q;
    d1_data_d = d1_push_d ? word : d1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc0_pop_q <= 1'b0;
      vc1_pop_q <= 1'b0;
      cur_q     <= 1'b0;
      cnt_q     <= 3'd0;
      valid1_q  <= 1'b0;
      src1_q    <= 1'b0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d0_data_q <= '0;
      d1_data_q <= '0;
    end else begin
      vc0_pop_q <= vc0_pop_d;
      vc1_pop_q <= vc1_pop_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      valid1_q  <= vc0_pop_q | vc1_pop_q;
      src1_q    <= vc1_pop_q;
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
      d0_data_q <= d0_data_d;
      d1_data_q <= d1_data_d;
    end
  end

  assign bus.vc0_pop = vc0_pop_q;
  assign bus.vc1_pop = vc1_pop_q;
  assign bus.d0_push = d0_push_q;
  assign bus.d1_push = d1_push_q;
  assign bus.d0_data = d0_data_q;
  assign bus.d1_data = d1_data_q;

  assign idle_o = ~(vc0_pop_q | vc1_pop_q | valid1_q | d0_push_q | d1_push_q)
                  & bus.vc0_empty & bus.vc1_empty;
endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: behavioural VC FIFOs plus a per-cycle table of
// expected pops, pushes, pushed data and idle, with hand sequences for reset cases.
module tb_vc_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_i = 1'b0;
  logic idle_o;
  int checks = 0;
  int errors = 0;

  vc_arbiter_if #(.DATA_WIDTH(6)) bus();

  vc_arbiter #(.data_width(6), .WEIGHT0(3), .WEIGHT1(1), .DEST_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .idle_o(idle_o), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic pend0 = 1'b0;
  logic pend1 = 1'b0;

  typedef struct {
    logic       en;    // enable driven after this row is checked
    logic       af;    // d1_almost_full driven after this row is checked
    logic [1:0] pop;   // {vc1_pop, vc0_pop}
    logic [1:0] push;  // {d1_push, d0_push}
    logic [5:0] data;
    logic       idle;
  } row_t;
  row_t tv[38];

  function automatic row_t mk(logic en, logic af, logic [1:0] pop, logic [1:0] push,
                              logic [5:0] data, logic idle);
    row_t r;
    r.en = en; r.af = af; r.pop = pop; r.push = push; r.data = data; r.idle = idle;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_flags();
    bus.vc0_empty        = (q0.size() == 0);
    bus.vc0_almost_empty = (q0.size() <= 1);
    bus.vc1_empty        = (q1.size() == 0);
    bus.vc1_almost_empty = (q1.size() <= 1);
  endtask

  // The FIFO executes a pop at the edge ending the pop cycle; applying it at the
  // following negedge is equivalent because the arbiter only samples at posedge.
  task automatic step();
    @(negedge clk);
    if (pend0 && q0.size() > 0) bus.vc0_data = q0.pop_front();
    if (pend1 && q1.size() > 0) bus.vc1_data = q1.pop_front();
    fifo_flags();
    #1;
    pend0 = bus.vc0_pop;
    pend1 = bus.vc1_pop;
  endtask

  task automatic seg_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    pend0 = 1'b0;
    pend1 = 1'b0;
    bus.vc0_data = 6'h00;
    bus.vc1_data = 6'h00;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    fifo_flags();
  endtask

  task automatic seg_go(logic en0);
    fifo_flags();
    enable_i = en0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_rows(int first, int n);
    for (int i = first; i < first + n; i++) begin
      step();
      chk($sformatf("row%0d pop", i), {6'b0, bus.vc1_pop, bus.vc0_pop}, {6'b0, tv[i].pop});
      chk($sformatf("row%0d push", i), {6'b0, bus.d1_push, bus.d0_push}, {6'b0, tv[i].push});
      if (tv[i].push[0]) chk($sformatf("row%0d d0_data", i), {2'b0, bus.d0_data}, {2'b0, tv[i].data});
      if (tv[i].push[1]) chk($sformatf("row%0d d1_data", i), {2'b0, bus.d1_data}, {2'b0, tv[i].data});
      chk($sformatf("row%0d idle", i), {7'b0, idle_o}, {7'b0, tv[i].idle});
      enable_i = tv[i].en;
      bus.d1_almost_full = tv[i].af;
    end
  endtask

  initial begin
    // Segment A: VC0/VC1 hold 8 words each, no pause (rows 0..18).
    tv[0]  = mk(1'b1, 1'b0, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[1]  = mk(1'b1, 1'b0, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[2]  = mk(1'b1, 1'b0, 2'b01, 2'b01, 6'h01, 1'b0);
    tv[3]  = mk(1'b1, 1'b0, 2'b10, 2'b10, 6'h12, 1'b0);
    tv[4]  = mk(1'b1, 1'b0, 2'b01, 2'b01, 6'h03, 1'b0);
    tv[5]  = mk(1'b1, 1'b0, 2'b01, 2'b01, 6'h21, 1'b0);
    tv[6]  = mk(1'b1, 1'b0, 2'b01, 2'b10, 6'h14, 1'b0);
    tv[7]  = mk(1'b1, 1'b0, 2'b10, 2'b01, 6'h05, 1'b0);
    tv[8]  = mk(1'b1, 1'b0, 2'b01, 2'b10, 6'h16, 1'b0);
    tv[9]  = mk(1'b1, 1'b0, 2'b01, 2'b10, 6'h32, 1'b0);
    tv[10] = mk(1'b1, 1'b0, 2'b10, 2'b01, 6'h07, 1'b0);
    tv[11] = mk(1'b1, 1'b0, 2'b10, 2'b10, 6'h18, 1'b0);
    tv[12] = mk(1'b1, 1'b0, 2'b10, 2'b01, 6'h23, 1'b0);
    tv[13] = mk(1'b1, 1'b0, 2'b10, 2'b10, 6'h34, 1'b0);
    tv[14] = mk(1'b1, 1'b0, 2'b10, 2'b01, 6'h25, 1'b0);
    tv[15] = mk(1'b1, 1'b0, 2'b10, 2'b10, 6'h36, 1'b0);
    tv[16] = mk(1'b1, 1'b0, 2'b00, 2'b01, 6'h27, 1'b0);
    tv[17] = mk(1'b1, 1'b0, 2'b00, 2'b10, 6'h38, 1'b0);
    tv[18] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b1);
    // Segment B: VC0 only, d1_almost_full high for 4 cycles mid-stream (rows 19..31).
    tv[19] = mk(1'b1, 1'b0, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[20] = mk(1'b1, 1'b1, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[21] = mk(1'b1, 1'b1, 2'b00, 2'b01, 6'h01, 1'b0);
    tv[22] = mk(1'b1, 1'b1, 2'b00, 2'b10, 6'h12, 1'b0);
    tv[23] = mk(1'b1, 1'b1, 2'b00, 2'b00, 6'h00, 1'b0);
    tv[24] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b0);
    tv[25] = mk(1'b1, 1'b0, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[26] = mk(1'b1, 1'b0, 2'b01, 2'b00, 6'h00, 1'b0);
    tv[27] = mk(1'b1, 1'b0, 2'b01, 2'b01, 6'h03, 1'b0);
    tv[28] = mk(1'b1, 1'b0, 2'b01, 2'b10, 6'h14, 1'b0);
    tv[29] = mk(1'b1, 1'b0, 2'b00, 2'b01, 6'h05, 1'b0);
    tv[30] = mk(1'b1, 1'b0, 2'b00, 2'b10, 6'h16, 1'b0);
    tv[31] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b1);
    // Segment C: single word in VC1, enable held low for the first two cycles (rows 32..37).
    tv[32] = mk(1'b0, 1'b0, 2'b00, 2'b00, 6'h00, 1'b0);
    tv[33] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b0);
    tv[34] = mk(1'b1, 1'b0, 2'b10, 2'b00, 6'h00, 1'b0);
    tv[35] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b0);
    tv[36] = mk(1'b1, 1'b0, 2'b00, 2'b01, 6'h2A, 1'b0);
    tv[37] = mk(1'b1, 1'b0, 2'b00, 2'b00, 6'h00, 1'b1);

    // Reset held: idle with empty FIFOs, then no strobes while the FIFOs hold data.
    seg_reset();
    @(negedge clk);
    #1;
    chk("reset idle empty", {7'b0, idle_o}, 8'h01);
    q0 = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16, 6'h07, 6'h18};
    q1 = '{6'h21, 6'h32, 6'h23, 6'h34, 6'h25, 6'h36, 6'h27, 6'h38};
    fifo_flags();
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset pops", {6'b0, bus.vc1_pop, bus.vc0_pop}, 8'h00);
    chk("reset pushes", {6'b0, bus.d1_push, bus.d0_push}, 8'h00);
    chk("reset d0_data", {2'b0, bus.d0_data}, 8'h00);
    chk("reset d1_data", {2'b0, bus.d1_data}, 8'h00);
    chk("reset idle busy", {7'b0, idle_o}, 8'h00);
    seg_go(1'b1);
    run_rows(0, 19);

    seg_reset();
    q0 = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16};
    seg_go(1'b1);
    run_rows(19, 13);

    seg_reset();
    q1 = '{6'h2A};
    seg_go(1'b0);
    run_rows(32, 6);

    // Asynchronous reset one cycle after a pop: in-flight words never push.
    seg_reset();
    q0 = '{6'h0B, 6'h1C, 6'h0D};
    seg_go(1'b1);
    step();
    chk("async pop c0", {7'b0, bus.vc0_pop}, 8'h01);
    step();
    chk("async pop c1", {7'b0, bus.vc0_pop}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("async pops drop", {6'b0, bus.vc1_pop, bus.vc0_pop}, 8'h00);
    chk("async pushes drop", {6'b0, bus.d1_push, bus.d0_push}, 8'h00);
    seg_reset();
    #1;
    chk("async idle", {7'b0, idle_o}, 8'h01);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post-reset c%0d pushes", c), {6'b0, bus.d1_push, bus.d0_push}, 8'h00);
      chk($sformatf("post-reset c%0d pops", c), {6'b0, bus.vc1_pop, bus.vc0_pop}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
